multicycle_data_path: RTL and testbench

- Next-generation ARM-subset datapath: multicycle instead of single-cycle, with one unified memory port using a req/ready handshake, so memory may insert wait states.
- Holds its own step sequencer (FETCH→DECODE→EXECUTE→MEM/WB), the register file, the ALU, immediate extension and architectural state registers.
- Decoded control comes from an external combinational decoder that is fed from the `instr` output.
- Sits between the core top and the memory subsystem.

---
 rtl/multicycle_pkg.sv | 22 ++
 rtl/mc_register_file.sv | 34 +++
 rtl/multicycle_data_path.sv | 172 +++++++++++++++++
 tb/tb_multicycle_data_path.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/multicycle_pkg.sv
// Shared types and encodings for the multicycle ARM-subset datapath.
package multicycle_pkg;

  typedef enum logic [2:0] {
    FETCH   = 3'd0,
    DECODE  = 3'd1,
    EXECUTE = 3'd2,
    MEMACC  = 3'd3,
    MEMWB   = 3'd4,
    ALUWB   = 3'd5
  } state_t;

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_AND = 2'b10;
  localparam logic [1:0] ALU_ORR = 2'b11;

  localparam logic [1:0] IMM_8  = 2'b00;
  localparam logic [1:0] IMM_12 = 2'b01;
  localparam logic [1:0] IMM_BR = 2'b10;

endpackage

// File: rtl/mc_register_file.sv
// R0-R14 register file: two asynchronous read ports, one synchronous write port.
// Address 15 reads as zero here; the parent substitutes the PC view of R15.
module mc_register_file #(
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [3:0]            ra_addr,
  input  logic [3:0]            rb_addr,
  output logic [DATA_WIDTH-1:0] ra_data,
  output logic [DATA_WIDTH-1:0] rb_data,
  input  logic                  we,
  input  logic [3:0]            wa,
  input  logic [DATA_WIDTH-1:0] wd
);

  logic [DATA_WIDTH-1:0] regs [15];

  always_comb begin
    ra_data = '0;
    rb_data = '0;
    if (ra_addr != 4'd15) ra_data = regs[ra_addr];
    if (rb_addr != 4'd15) rb_data = regs[rb_addr];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < 15; i++) regs[i] <= '0;
    end else if (we && wa != 4'd15) begin
      regs[wa] <= wd;
    end
  end

endmodule

// File: rtl/multicycle_data_path.sv
// Multicycle ARM-subset datapath: step sequencer, register file, ALU, immediate
// extension and architectural state behind a single req/ready memory port.
module multicycle_data_path
  import multicycle_pkg::*;
#(
  parameter int unsigned           DATA_WIDTH   = 32,
  parameter logic [DATA_WIDTH-1:0] RESET_VECTOR = '0,
  parameter int unsigned           PC_STEP      = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [DATA_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  input  logic                  mem_ready,
  output logic [31:0]           instr,
  input  logic                  dec_mem,
  input  logic                  dec_load,
  input  logic                  dec_branch,
  input  logic                  dec_reg_write,
  input  logic                  dec_set_flags,
  input  logic                  dec_alu_src,
  input  logic [1:0]            dec_imm_src,
  input  logic [1:0]            dec_alu_ctl,
  input  logic [1:0]            dec_reg_src,
  input  logic                  cond_ok,
  output logic [3:0]            alu_flags,
  output logic [DATA_WIDTH-1:0] pc,
  output logic [2:0]            state
);

  localparam logic [DATA_WIDTH-1:0] STEP = DATA_WIDTH'(PC_STEP);

  state_t                state_q;
  logic [DATA_WIDTH-1:0] pc_q, a_q, b_q, imm_q, alu_out_q, mdr_q;
  logic [31:0]           ir_q;
  logic [3:0]            flags_q;

  logic [3:0]            rd, ra_addr, rb_addr;
  logic [DATA_WIDTH-1:0] rf_a, rf_b, rd_a, rd_b, pc_plus, imm_ext;
  logic [DATA_WIDTH-1:0] opb, opb_x, alu_res;
  logic [DATA_WIDTH:0]   sum;
  logic                  is_sub, c_flag, v_flag;
  logic                  wb_en, rf_we;
  logic [DATA_WIDTH-1:0] wb_data;

  assign rd      = ir_q[15:12];
  assign ra_addr = dec_reg_src[1] ? 4'd15 : ir_q[19:16];
  assign rb_addr = dec_reg_src[0] ? ir_q[15:12] : ir_q[3:0];
  assign pc_plus = pc_q + STEP;

  // In DECODE pc already points past this instruction, so R15 reads as fetch address + 8.
  assign rd_a = (ra_addr == 4'd15) ? pc_plus : rf_a;
  assign rd_b = (rb_addr == 4'd15) ? pc_plus : rf_b;

  always_comb begin
    imm_ext = '0;
    case (dec_imm_src)
      IMM_8:   imm_ext = DATA_WIDTH'(ir_q[7:0]);
      IMM_12:  imm_ext = DATA_WIDTH'(ir_q[11:0]);
      IMM_BR:  imm_ext = {{(DATA_WIDTH-26){ir_q[23]}}, ir_q[23:0], 2'b00};
      default: imm_ext = '0;
    endcase
  end

  always_comb begin
    opb     = dec_alu_src ? imm_q : b_q;
    is_sub  = (dec_alu_ctl == ALU_SUB);
    opb_x   = is_sub ? ~opb : opb;
    sum     = {1'b0, a_q} + {1'b0, opb_x} + (DATA_WIDTH+1)'(is_sub);
    alu_res = sum[DATA_WIDTH-1:0];
    c_flag  = sum[DATA_WIDTH];
    v_flag  = (a_q[DATA_WIDTH-1] == opb_x[DATA_WIDTH-1]) &&
              (sum[DATA_WIDTH-1] != a_q[DATA_WIDTH-1]);
    case (dec_alu_ctl)
      ALU_AND: begin alu_res = a_q & opb; c_flag = 1'b0; v_flag = 1'b0; end
      ALU_ORR: begin alu_res = a_q | opb; c_flag = 1'b0; v_flag = 1'b0; end
      default: ;
    endcase
  end

  always_comb begin
    wb_en   = 1'b0;
    wb_data = alu_out_q;
    if (state_q == ALUWB) wb_en = dec_reg_write;
    if (state_q == MEMWB) begin
      wb_en   = 1'b1;
      wb_data = mdr_q;
    end
  end
  assign rf_we = wb_en && (rd != 4'd15);

  mc_register_file #(.DATA_WIDTH(DATA_WIDTH)) u_regfile (
    .clk     (clk),
    .reset   (reset),
    .ra_addr (ra_addr),
    .rb_addr (rb_addr),
    .ra_data (rf_a),
    .rb_data (rf_b),
    .we      (rf_we),
    .wa      (rd),
    .wd      (wb_data)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= FETCH;
      pc_q      <= RESET_VECTOR;
      ir_q      <= '0;
      flags_q   <= '0;
      a_q       <= '0;
      b_q       <= '0;
      imm_q     <= '0;
      alu_out_q <= '0;
      mdr_q     <= '0;
    end else begin
      case (state_q)
        FETCH: if (mem_ready) begin
          ir_q    <= mem_rdata[31:0];
          pc_q    <= pc_plus;
          state_q <= DECODE;
        end
        DECODE: begin
          a_q     <= rd_a;
          b_q     <= rd_b;
          imm_q   <= imm_ext;
          state_q <= EXECUTE;
        end
        EXECUTE: begin
          alu_out_q <= alu_res;
          if (!cond_ok) begin
            state_q <= FETCH;
          end else if (dec_branch) begin
            pc_q    <= alu_res;
            state_q <= FETCH;
          end else if (dec_mem) begin
            state_q <= MEMACC;
          end else begin
            if (dec_set_flags)
              flags_q <= {alu_res[DATA_WIDTH-1], alu_res == '0, c_flag, v_flag};
            state_q <= ALUWB;
          end
        end
        MEMACC: if (mem_ready) begin
          if (dec_load) begin
            mdr_q   <= mem_rdata;
            state_q <= MEMWB;
          end else begin
            state_q <= FETCH;
          end
        end
        MEMWB, ALUWB: begin
          if (wb_en && rd == 4'd15) pc_q <= wb_data;
          state_q <= FETCH;
        end
        default: state_q <= FETCH;
      endcase
    end
  end

  assign mem_req   = !reset && (state_q == FETCH || state_q == MEMACC);
  assign mem_we    = (state_q == MEMACC) && !dec_load;
  assign mem_addr  = (state_q == MEMACC) ? alu_out_q : pc_q;
  assign mem_wdata = b_q;
  assign instr     = ir_q;
  assign alu_flags = flags_q;
  assign pc        = pc_q;
  assign state     = state_q;

endmodule

// File: tb/tb_multicycle_data_path.sv
// Directed bench: the bench plays both memory and decoder, one instruction at a time.
module tb_multicycle_data_path;
  import multicycle_pkg::*;

  typedef struct packed {
    logic       mem, load, branch, reg_write, set_flags, alu_src;
    logic [1:0] imm_src, alu_ctl, reg_src;
    logic       cond_ok;
  } dec_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        mem_req, mem_we, mem_ready = 1'b0;
  logic [31:0] mem_addr, mem_wdata, mem_rdata = '0, instr, pc;
  logic [3:0]  alu_flags;
  logic [2:0]  state;
  dec_t        dec = '0;

  int unsigned checks = 0;
  int unsigned failures = 0;

  int unsigned last_cycles;
  logic [31:0] acc_addr, acc_wdata;
  logic        acc_we, acc_stable;

  always #5 clk = ~clk;

  multicycle_data_path #(
    .DATA_WIDTH   (32),
    .RESET_VECTOR (32'h100),
    .PC_STEP      (4)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .mem_req       (mem_req),
    .mem_we        (mem_we),
    .mem_addr      (mem_addr),
    .mem_wdata     (mem_wdata),
    .mem_rdata     (mem_rdata),
    .mem_ready     (mem_ready),
    .instr         (instr),
    .dec_mem       (dec.mem),
    .dec_load      (dec.load),
    .dec_branch    (dec.branch),
    .dec_reg_write (dec.reg_write),
    .dec_set_flags (dec.set_flags),
    .dec_alu_src   (dec.alu_src),
    .dec_imm_src   (dec.imm_src),
    .dec_alu_ctl   (dec.alu_ctl),
    .dec_reg_src   (dec.reg_src),
    .cond_ok       (dec.cond_ok),
    .alu_flags     (alu_flags),
    .pc            (pc),
    .state         (state)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] enc(input logic [3:0] rn, input logic [3:0] rd,
                                      input logic [11:0] imm);
    return {12'h000, rn, rd, imm};
  endfunction

  function automatic dec_t d_dp(input logic [1:0] ctl, input logic s, input logic cond);
    dec_t d = '0;
    d.reg_write = 1'b1; d.set_flags = s; d.alu_src = 1'b1;
    d.imm_src = IMM_8; d.alu_ctl = ctl; d.cond_ok = cond;
    return d;
  endfunction

  function automatic dec_t d_mem(input logic ld);
    dec_t d = '0;
    d.mem = 1'b1; d.load = ld; d.alu_src = 1'b1; d.imm_src = IMM_12;
    d.alu_ctl = ALU_ADD; d.reg_src = 2'b01; d.cond_ok = 1'b1;
    return d;
  endfunction

  function automatic dec_t d_br(input logic cond);
    dec_t d = '0;
    d.branch = 1'b1; d.alu_src = 1'b1; d.imm_src = IMM_BR;
    d.alu_ctl = ALU_ADD; d.reg_src = 2'b10; d.cond_ok = cond;
    return d;
  endfunction

  // Runs one instruction from FETCH back to FETCH; mem_ready is asserted in
  // non-memory states on purpose, since the datapath must ignore it there.
  task automatic exec(input logic [31:0] ir, input dec_t d, input int unsigned fwait,
                      input int unsigned mwait, input logic [31:0] ld);
    int unsigned fcnt = 0, mcnt = 0, cyc = 0;
    bit left = 0, seen = 0;
    dec = d;
    acc_stable = 1'b1;
    acc_addr = '0; acc_we = 1'b0; acc_wdata = '0;
    forever begin
      @(negedge clk);
      case (state)
        FETCH: begin
          mem_rdata = ir;
          mem_ready = (fcnt >= fwait);
          fcnt++;
        end
        MEMACC: begin
          if (!seen) begin
            acc_addr = mem_addr; acc_we = mem_we; acc_wdata = mem_wdata; seen = 1;
          end else if (mem_addr !== acc_addr || mem_we !== acc_we || mem_wdata !== acc_wdata) begin
            acc_stable = 1'b0;
          end
          if (mem_req !== 1'b1) acc_stable = 1'b0;
          mem_rdata = ld;
          mem_ready = (mcnt >= mwait);
          mcnt++;
        end
        default: begin
          mem_rdata = 32'hDEAD_BEEF;
          mem_ready = 1'b1;
        end
      endcase
      @(posedge clk);
      #1;
      cyc++;
      if (state != FETCH) left = 1;
      if (left && state == FETCH) break;
      if (cyc >= 60) begin
        check("timeout", cyc, 0);
        break;
      end
    end
    mem_ready = 1'b0;
    last_cycles = cyc;
  endtask

  initial begin
    // Reset
    repeat (2) @(posedge clk);
    #1;
    check("rst_pc", pc, 32'h100);
    check("rst_state", state, FETCH);
    check("rst_flags", alu_flags, 4'b0000);
    check("rst_instr", instr, 32'h0);
    check("rst_req", mem_req, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("fetch_req", mem_req, 1'b1);
    check("fetch_addr", mem_addr, 32'h100);
    check("fetch_we", mem_we, 1'b0);

    // ADD R1,R0,#5
    exec(enc(4'd0, 4'd1, 12'd5), d_dp(ALU_ADD, 1'b0, 1'b1), 0, 0, '0);
    check("add_cycles", last_cycles, 4);
    check("add_pc", pc, 32'h104);

    // STR R1,[R0,#0x40] with 3 wait states
    exec(enc(4'd0, 4'd1, 12'h040), d_mem(1'b0), 0, 3, '0);
    check("str_cycles", last_cycles, 7);
    check("str_addr", acc_addr, 32'h40);
    check("str_we", acc_we, 1'b1);
    check("str_wdata_r1", acc_wdata, 32'd5);
    check("str_stable", acc_stable, 1'b1);

    // SUBS R2,R1,#5
    exec(enc(4'd1, 4'd2, 12'd5), d_dp(ALU_SUB, 1'b1, 1'b1), 0, 0, '0);
    check("subs_flags", alu_flags, 4'b0110);
    check("subs_pc", pc, 32'h10C);

    // LDR R3,[R0,#0x40] with 3 wait states
    exec(enc(4'd0, 4'd3, 12'h040), d_mem(1'b1), 0, 3, 32'hCAFE_0001);
    check("ldr_cycles", last_cycles, 8);
    check("ldr_addr", acc_addr, 32'h40);
    check("ldr_we", acc_we, 1'b0);
    check("ldr_stable", acc_stable, 1'b1);

    exec(enc(4'd0, 4'd3, 12'h044), d_mem(1'b0), 0, 0, '0);
    check("ldr_result_r3", acc_wdata, 32'hCAFE_0001);
    check("str_addr2", acc_addr, 32'h44);

    // LDR R4 = 0x7FFFFFFF, then ADDS R5,R4,#1 overflows
    exec(enc(4'd0, 4'd4, 12'h050), d_mem(1'b1), 0, 0, 32'h7FFF_FFFF);
    check("ldr0_cycles", last_cycles, 5);
    exec(enc(4'd4, 4'd5, 12'd1), d_dp(ALU_ADD, 1'b1, 1'b1), 0, 0, '0);
    check("adds_ovf_flags", alu_flags, 4'b1001);

    // ANDS R6,R4,#0
    exec(enc(4'd4, 4'd6, 12'd0), d_dp(ALU_AND, 1'b1, 1'b1), 0, 0, '0);
    check("ands_zero_flags", alu_flags, 4'b0100);

    // ADDS R3,R0,#7 with condition failed: no register or flag change
    exec(enc(4'd0, 4'd3, 12'd7), d_dp(ALU_ADD, 1'b1, 1'b0), 1, 0, '0);
    check("cfail_cycles", last_cycles, 4);
    check("cfail_flags", alu_flags, 4'b0100);
    exec(enc(4'd0, 4'd3, 12'h044), d_mem(1'b0), 0, 0, '0);
    check("cfail_r3", acc_wdata, 32'hCAFE_0001);

    // ORRS R7,R5,#1 -> 0x80000001, N only
    exec(enc(4'd5, 4'd7, 12'd1), d_dp(ALU_ORR, 1'b1, 1'b1), 0, 0, '0);
    check("orrs_flags", alu_flags, 4'b1000);
    exec(enc(4'd0, 4'd7, 12'h060), d_mem(1'b0), 0, 0, '0);
    check("orrs_r7", acc_wdata, 32'h8000_0001);

    // ADD R15,R0,#0x200 writes the PC
    begin
      dec_t d = d_dp(ALU_ADD, 1'b0, 1'b1);
      d.imm_src = IMM_12;
      exec(enc(4'd0, 4'd15, 12'h200), d, 0, 0, '0);
    end
    check("wb_r15_pc", pc, 32'h200);

    // B +2 words at 0x200, two fetch wait states
    exec(32'hEA00_0002, d_br(1'b1), 2, 0, '0);
    check("b_cycles", last_cycles, 5);
    check("b_pc", pc, 32'h210);
    exec(32'h0A00_0002, d_br(1'b0), 0, 0, '0);
    check("b_nottaken_cycles", last_cycles, 3);
    check("b_nottaken_pc", pc, 32'h214);

    // Reset during a load's MEMACC wait
    dec = d_mem(1'b1);
    for (int i = 0; i < 10 && state != MEMACC; i++) begin
      @(negedge clk);
      mem_rdata = enc(4'd0, 4'd1, 12'h048);
      mem_ready = (state == FETCH);
      @(posedge clk);
      #1;
    end
    check("reach_memacc", state, MEMACC);
    repeat (2) begin
      @(negedge clk);
      mem_ready = 1'b0;
    end
    @(negedge clk);
    reset = 1'b1;
    mem_ready = 1'b1;
    mem_rdata = 32'h1234_5678;
    @(posedge clk);
    #1;
    check("rst_mid_state", state, FETCH);
    check("rst_mid_pc", pc, 32'h100);
    check("rst_mid_req", mem_req, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    mem_ready = 1'b0;
    exec(enc(4'd0, 4'd1, 12'h04C), d_mem(1'b0), 0, 0, '0);
    check("rst_mid_r1", acc_wdata, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
